// File: rtl/shifter_arbiter.sv
// shifter_arbiter: shares one combinational 4-bit left shifter (y = a << b) between two
// requesters. Round-robin arbitration over valid/ready handshakes; one registered result
// slot tagged with the id of the requester that produced it.
//
// Ports:
//   clk, rst_n                 clock (rising edge), asynchronous active-low reset
//   req{0,1}_valid_i           requester has an operation
//   req{0,1}_a_i, req{0,1}_b_i operand (4 bits) and shift amount (2 bits)
//   req{0,1}_ready_o           operation accepted this cycle
//   rsp_valid_o                result register holds a result
//   rsp_y_o, rsp_id_o          registered result and the requester that owns it
//   rsp_ready_i                consumer takes the result
//   grant_cnt{0,1}_o           saturating grant counters (only with SHIFTER_ARB_STATS_EN)
//
// Build option: define SHIFTER_ARB_STATS_EN to add the grant counters. Arbitration and
// timing are the same either way.
module shifter_arbiter #(
   parameter bit          PRIO_INIT = 1'b0,
   parameter int unsigned CNT_W     = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid_i,
   input  logic [3:0]       req0_a_i,
   input  logic [1:0]       req0_b_i,
   output logic             req0_ready_o,
   input  logic             req1_valid_i,
   input  logic [3:0]       req1_a_i,
   input  logic [1:0]       req1_b_i,
   output logic             req1_ready_o,
   output logic             rsp_valid_o,
   output logic [6:0]       rsp_y_o,
   output logic             rsp_id_o,
   input  logic             rsp_ready_i
`ifdef SHIFTER_ARB_STATS_EN
   ,
   output logic [CNT_W-1:0] grant_cnt0_o,
   output logic [CNT_W-1:0] grant_cnt1_o
`endif
);

   typedef enum logic {StEmpty, StFull} state_e;

   state_e     state_q, state_d;
   logic       prio_q, prio_d;
   logic [6:0] rsp_y_q, rsp_y_d;
   logic       rsp_id_q, rsp_id_d;

   logic       open_w;
   logic       gnt0, gnt1, gnt;
   logic [3:0] sh_a;
   logic [1:0] sh_b;
   logic [6:0] sh_y;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StEmpty;
         prio_q   <= PRIO_INIT;
         rsp_y_q  <= 7'd0;
         rsp_id_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         prio_q   <= prio_d;
         rsp_y_q  <= rsp_y_d;
         rsp_id_q <= rsp_id_d;
      end
   end

   // Grant: the slot is open when empty or being drained this cycle, so a full slot can
   // be reloaded back-to-back. The pointer only breaks ties.
   always_comb begin
      open_w = (state_q == StEmpty) | rsp_ready_i;
      gnt0   = 1'b0;
      gnt1   = 1'b0;
      if (open_w) begin
         if (req0_valid_i && req1_valid_i) begin
            gnt0 = ~prio_q;
            gnt1 = prio_q;
         end else begin
            gnt0 = req0_valid_i;
            gnt1 = req1_valid_i;
         end
      end
      gnt = gnt0 | gnt1;
   end

   // Shared shifter, fed by the granted requester
   always_comb begin
      sh_a = gnt1 ? req1_a_i : req0_a_i;
      sh_b = gnt1 ? req1_b_i : req0_b_i;
      sh_y = {3'b000, sh_a} << sh_b;
   end

   // Next state
   always_comb begin
      state_d  = state_q;
      prio_d   = prio_q;
      rsp_y_d  = rsp_y_q;
      rsp_id_d = rsp_id_q;
      if (gnt) begin
         state_d  = StFull;
         prio_d   = ~gnt1;
         rsp_y_d  = sh_y;
         rsp_id_d = gnt1;
      end else if (state_q == StFull && rsp_ready_i) begin
         state_d = StEmpty;
      end
   end

   // Outputs
   always_comb begin
      req0_ready_o = gnt0;
      req1_ready_o = gnt1;
      rsp_valid_o  = (state_q == StFull);
      rsp_y_o      = rsp_y_q;
      rsp_id_o     = rsp_id_q;
   end

`ifdef SHIFTER_ARB_STATS_EN
   localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [CNT_W-1:0] cnt0_q, cnt1_q;

   // Saturating grant counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt0_q <= '0;
         cnt1_q <= '0;
      end else begin
         if (gnt0 && cnt0_q != '1) cnt0_q <= cnt0_q + CntOne;
         if (gnt1 && cnt1_q != '1) cnt1_q <= cnt1_q + CntOne;
      end
   end

   assign grant_cnt0_o = cnt0_q;
   assign grant_cnt1_o = cnt1_q;
`else
   logic unused_cnt_w;
   assign unused_cnt_w = (CNT_W == 0);
`endif

endmodule
